// File: rtl/axi_lite_m1_if.sv
// CPU-side request/response port plus the five AXI4-Lite channels of axi_lite_m1.
// The master modport is the manager's view; the slave modport is the core and subordinate side.
interface axi_lite_m1_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  localparam int STRB_W = DATA_W / 8;

  // CPU-side request / response
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  // AXI4-Lite read channels
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  // AXI4-Lite write channels
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_m1.sv
// AXI4-Lite manager: turns one CPU request at a time into an AXI-Lite read or write.
// Every handshake is valid/ready: a transfer happens on a rising edge where both are high; a raised valid and its payload hold until that edge.
module axi_lite_m1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  axi_lite_m1_if.master       bus,
  output logic [2:0]          dbg_state
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RESP    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              accept;

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  // Next state; the write channels complete independently, tracked by the done flags
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = bus.req_wen ? WR_REQ : RD_ADDR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      RD_ADDR: if (arvalid_q && bus.arready) state_d = RD_DATA;
      RD_DATA: if (rready_q && bus.rvalid)   state_d = RESP;
      WR_REQ: begin
        aw_done_d = aw_done_q || (awvalid_q && bus.awready);
        w_done_d  = w_done_q  || (wvalid_q  && bus.wready);
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: if (bready_q && bus.bvalid)   state_d = RESP;
      RESP:    if (resp_valid_q && bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight out of flops
  always_comb begin
    arvalid_d    = (state_d == RD_ADDR);
    rready_d     = (state_d == RD_DATA);
    awvalid_d    = (state_d == WR_REQ) && !aw_done_d;
    wvalid_d     = (state_d == WR_REQ) && !w_done_d;
    bready_d     = (state_d == WR_RESP);
    resp_valid_d = (state_d == RESP);
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (accept) begin
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      wstrb_d = bus.req_wstrb;
    end
    if (state_q == RD_DATA && rready_q && bus.rvalid) begin
      resp_rdata_d = bus.rdata;
      resp_err_d   = (bus.rresp != 2'b00);
    end
    if (state_q == WR_RESP && bready_q && bus.bvalid) begin
      resp_rdata_d = '0;
      resp_err_d   = (bus.bresp != 2'b00);
    end
  end

  assign bus.araddr     = addr_q;
  assign bus.arvalid    = arvalid_q;
  assign bus.rready     = rready_q;
  assign bus.awaddr     = addr_q;
  assign bus.awvalid    = awvalid_q;
  assign bus.wdata      = wdata_q;
  assign bus.wstrb      = wstrb_q;
  assign bus.wvalid     = wvalid_q;
  assign bus.bready     = bready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign dbg_state      = state_q;
endmodule
